// File: rtl/past_sum_arbiter_pkg.sv
// Shared sizing helpers for the past-sum arbiter slice.
package past_sum_arbiter_pkg;

  localparam int DEF_DATA_WIDTH = 4;
  localparam int DEF_N          = 2;
  localparam int DEF_NUM_CH     = 4;

  // Number of history entries per channel.
  function automatic int win_depth(input int n);
    return 1 << n;
  endfunction

  // A sum of 2^n samples of dw bits each needs dw+n bits.
  function automatic int sum_width(input int dw, input int n);
    return dw + n;
  endfunction

  // Width of a channel index, never narrower than one bit.
  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/past_sum_arbiter_if.sv
// Request/grant and result bus between the requesters and the arbiter.
interface past_sum_arbiter_if
  import past_sum_arbiter_pkg::*;
#(
  parameter int data_width = DEF_DATA_WIDTH,
  parameter int N          = DEF_N,
  parameter int NUM_CH     = DEF_NUM_CH
);
  localparam int SW = sum_width(data_width, N);
  localparam int CW = ch_width(NUM_CH);

  logic [NUM_CH-1:0]            req;
  logic [NUM_CH*data_width-1:0] req_data;
  logic [NUM_CH-1:0]            gnt;
  logic                         out_valid;
  logic                         out_ready;
  logic [CW-1:0]                out_ch;
  logic [SW-1:0]                out_sum;

  modport master (
    output req, req_data, out_ready,
    input  gnt, out_valid, out_ch, out_sum
  );

  modport slave (
    input  req, req_data, out_ready,
    output gnt, out_valid, out_ch, out_sum
  );
endinterface

// File: rtl/past_sum_arbiter_rr_arbiter.sv
// Round-robin grant: one-hot pick of the first requester after ptr.
module rr_arbiter
  import past_sum_arbiter_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  localparam int CW    = ch_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CW-1:0]     ptr,
  input  logic              en,
  output logic [NUM_CH-1:0] gnt
);

  // Scan ptr+1, ptr+2, ... ptr (mod NUM_CH); the first active request wins.
  always_comb begin
    logic [CW-1:0] idx;
    gnt = '0;
    idx = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = CW'((int'(ptr) + k) % NUM_CH);
      if (en && (gnt == '0) && req[idx]) gnt[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/past_sum_arbiter.sv
// Round-robin sample collector returning each channel's sliding-window sum.
module past_sum_arbiter
  import past_sum_arbiter_pkg::*;
#(
  parameter int data_width = DEF_DATA_WIDTH,
  parameter int N          = DEF_N,
  parameter int NUM_CH     = DEF_NUM_CH
) (
  input logic               clk,
  input logic               rst,
  input logic               clr,
  past_sum_arbiter_if.slave bus
);

  localparam int W  = win_depth(N);
  localparam int SW = sum_width(data_width, N);
  localparam int CW = ch_width(NUM_CH);

  logic                      stall;
  logic                      grant_en;
  logic                      xfer;
  logic [NUM_CH-1:0]         gnt;
  logic [CW-1:0]             gnt_idx;
  logic [CW-1:0]             last_granted;
  logic [NUM_CH-1:0][SW-1:0] new_sum;
  logic                      out_valid_q;
  logic [CW-1:0]             out_ch_q;
  logic [SW-1:0]             out_sum_q;

  // A held result blocks new grants; clr also suppresses them.
  assign stall    = out_valid_q && !bus.out_ready;
  assign grant_en = !stall && !clr;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
    .req (bus.req),
    .ptr (last_granted),
    .en  (grant_en),
    .gnt (gnt)
  );

  assign xfer = |gnt;

  // One-hot grant to channel index.
  always_comb begin
    gnt_idx = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (gnt[c]) gnt_idx = CW'(c);
    end
  end

  // Pointer survives clr so fairness is not reset by a history flush.
  always_ff @(posedge clk) begin
    if (rst)       last_granted <= CW'(NUM_CH - 1);
    else if (xfer) last_granted <= gnt_idx;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [data_width-1:0] hist [W];
    logic [N-1:0]          wr_idx;
    logic [SW-1:0]         sum;
    logic [data_width-1:0] sample;

    assign sample = bus.req_data[c*data_width +: data_width];
    // Intermediate may exceed SW bits, but the modular result is exact.
    assign new_sum[c] = sum + SW'(sample) - SW'(hist[wr_idx]);

    // Per-channel window: replace the oldest entry and track the running sum.
    always_ff @(posedge clk) begin
      if (rst || clr) begin
        sum    <= '0;
        wr_idx <= '0;
        for (int i = 0; i < W; i++) hist[i] <= '0;
      end else if (gnt[c]) begin
        sum          <= new_sum[c];
        hist[wr_idx] <= sample;
        wr_idx       <= wr_idx + 1'b1;
      end
    end
  end

  // Result register: loads on transfer, holds while stalled, else empties.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_sum_q   <= '0;
    end else if (clr) begin
      out_valid_q <= 1'b0;
    end else if (stall) begin
      out_valid_q <= out_valid_q;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_ch_q    <= gnt_idx;
      out_sum_q   <= new_sum[gnt_idx];
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.gnt       = gnt;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_sum   = out_sum_q;

endmodule
